descriptor_fetch_master: RTL and testbench
==========================================

Name: descriptor_fetch_master

Overview:
- Avalon-MM read master that walks a linked list of DMA descriptors in the on-chip descriptor memory.
- Fetches each 4-word descriptor and checks the ownership bit.
- Presents the descriptor to the DMA engine over a valid/ready interface, then follows the next-pointer.
- Sits between the descriptor memory's slave port (through the interconnect) and the DMA datapath control.

Parameters:
- ADDR_WIDTH, 12, byte-address width of master port (1024 words x 4 bytes).
- DESC_WORDS, 4, words per descriptor; fixed at 4 in this revision.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin chain at start_ptr (ignored while busy)
- start_ptr  in  ADDR_WIDTH  byte address of first descriptor
- abort  in  1  level: stop chain at next safe point
- m_address  out  ADDR_WIDTH  Avalon byte address
- m_read  out  1  Avalon read request
- m_readdata  in  32  Avalon read data
- m_waitrequest  in  1  Avalon wait
- m_readdatavalid  in  1  Avalon read data valid
- desc_src  out  32  word0: source address
- desc_dst  out  32  word1: destination address
- desc_next  out  32  word2: next descriptor byte pointer
- desc_ctrl  out  16  word3[31:16]; bit15 of field (word3[31]) = OWNED_BY_HW
- desc_len  out  16  word3[15:0]: byte count
- desc_valid  out  1  descriptor presented
- desc_ready  in  1  DMA engine accepts descriptor
- busy  out  1  high in any state except IDLE
- chain_done  out  1  one-cycle pulse at normal end of chain
- error  out  1  one-cycle pulse on misaligned pointer; chain ends

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: m_address, m_read, desc_* fields, desc_valid, busy, chain_done, error.
  - Word counter 0.
- States: IDLE, REQ, WAIT, CHECK, PRESENT.
- IDLE:
  - start=1 with start_ptr[3:0]==0: latch ptr, word counter=0, go to REQ.
  - start=1 with start_ptr[3:0]!=0: error pulse next cycle; stay IDLE.
- REQ: m_read=1, m_address=ptr+4*counter.
  - Address and read held stable while m_waitrequest=1.
  - Go to WAIT on the first cycle with m_waitrequest=0.
- Outstanding reads: exactly one at a time.
- WAIT: m_read=0.
  - On m_readdatavalid: capture m_readdata into word[counter].
  - counter<3: increment counter, go to REQ.
  - counter==3: go to CHECK.
  - Minimum 2 cycles per word with zero wait states and latency 1, so a descriptor takes at least 8 cycles from first REQ to CHECK.
- CHECK (one cycle):
  - OWNED_BY_HW==0: chain_done pulse, go to IDLE; descriptor not presented.
  - abort==1: chain_done pulse, go to IDLE.
  - Otherwise: desc_valid=1, go to PRESENT.
- PRESENT:
  - desc_* outputs stable while desc_valid=1 and desc_ready=0.
  - On desc_valid & desc_ready: desc_valid=0 the next cycle, then:
    - desc_next==0 or abort==1: chain_done pulse, go to IDLE.
    - desc_next[3:0]!=0: error pulse, go to IDLE.
    - Otherwise: ptr=desc_next[ADDR_WIDTH-1:0], counter=0, go to REQ.
- abort during REQ/WAIT: the in-flight read completes (never drop m_read while waitrequest=1, always consume its readdatavalid). Chain then ends at CHECK with chain_done; no descriptor is presented.
- m_readdatavalid outside WAIT: ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is not checked. Upper pointer bits above ADDR_WIDTH are ignored.
- desc_* registers hold the last fetched descriptor after chain end until the next fetch overwrites them.
- busy=1 from the cycle after an accepted start until return to IDLE, inclusive of the chain_done/error cycle.
- start while busy: ignored.
- Asynchronous reset mid-transaction: immediate return to IDLE, m_read=0. A late readdatavalid is ignored.

Test Plan:
- Single descriptor at 0x040: words {0x1000,0x2000,0x0,0x8000_0100} -> 4 reads at 0x040,0x044,0x048,0x04C; desc_valid with src=0x1000, dst=0x2000, ctrl=0x8000, len=0x0100; after desc_ready: chain_done pulse, busy=0.
- Two-descriptor chain 0x000 -> 0x010 (second word3=0x8000_0040, next=0) -> both presented in order; reads at 0x010..0x01C occur only after the first handshake; one chain_done.
- Ownership clear: second descriptor word3=0x0000_0040 -> exactly one desc_valid; chain_done at CHECK.
- Backpressure and waitrequest: desc_ready low 5 cycles and m_waitrequest high 3 cycles on word1 -> outputs and m_address stable throughout; data correct.
- Misaligned: start_ptr=0x044 -> error pulse, no m_read. Next=0x018 -> error pulse after the first descriptor is accepted.
- Abort asserted during WAIT of word2 -> word2 and word3 reads complete, no desc_valid, chain_done; reset_n low mid-REQ -> m_read=0 and busy=0 immediately.

Source files
------------

// File: rtl/descriptor_fetch_master.sv
// Avalon-MM read master walking a linked list of 4-word DMA descriptors.
// Each descriptor is fetched, ownership-checked, handed to the DMA engine, then its next pointer is followed.
module descriptor_fetch_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DESC_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_ptr,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    input  logic [31:0]           m_readdata,
    input  logic                  m_waitrequest,
    input  logic                  m_readdatavalid,
    output logic [31:0]           desc_src,
    output logic [31:0]           desc_dst,
    output logic [31:0]           desc_next,
    output logic [15:0]           desc_ctrl,
    output logic [15:0]           desc_len,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic                  busy,
    output logic                  chain_done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_PRESENT
    } state_t;

    localparam logic [1:0] LAST_WORD = 2'(DESC_WORDS - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           src_q, src_d;
    logic [31:0]           dst_q, dst_d;
    logic [31:0]           next_q, next_d;
    logic [31:0]           w3_q, w3_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  end_q, end_d;
    logic                  abort_q, abort_d;
    logic                  abort_eff;

    // abort is remembered so a short pulse during a fetch still ends the chain at CHECK
    assign abort_eff = abort | abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            next_q  <= '0;
            w3_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            end_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            next_q  <= next_d;
            w3_q    <= w3_d;
            done_q  <= done_d;
            err_q   <= err_d;
            end_q   <= end_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        next_d  = next_q;
        w3_d    = w3_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        end_d   = 1'b0;
        abort_d = abort_q | abort;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    if (start_ptr[3:0] == 4'h0) begin
                        ptr_d   = start_ptr;
                        cnt_d   = 2'd0;
                        state_d = S_REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (!m_waitrequest) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_readdatavalid) begin
                    case (cnt_q)
                        2'd0:    src_d  = m_readdata;
                        2'd1:    dst_d  = m_readdata;
                        2'd2:    next_d = m_readdata;
                        default: w3_d   = m_readdata;
                    endcase
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_REQ;
                    end
                end
            end
            S_CHECK: begin
                if (!w3_q[31] || abort_eff) begin
                    done_d  = 1'b1;
                    end_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (desc_ready) begin
                    if (next_q == 32'h0 || abort_eff) begin
                        done_d  = 1'b1;
                        end_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (next_q[3:0] != 4'h0) begin
                        err_d   = 1'b1;
                        end_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ptr_d   = next_q[ADDR_WIDTH-1:0];
                        cnt_d   = 2'd0;
                        state_d = S_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_read     = (state_q == S_REQ);
    assign m_address  = ptr_q + ADDR_WIDTH'({cnt_q, 2'b00});
    assign desc_src   = src_q;
    assign desc_dst   = dst_q;
    assign desc_next  = next_q;
    assign desc_ctrl  = w3_q[31:16];
    assign desc_len   = w3_q[15:0];
    assign desc_valid = (state_q == S_PRESENT);
    // end_q stretches busy over the chain_done/error cycle after the return to IDLE
    assign busy       = (state_q != S_IDLE) | end_q;
    assign chain_done = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_descriptor_fetch_master.sv
// Directed bench for descriptor_fetch_master: Avalon slave model with memory plus a DMA-side monitor.
module tb_descriptor_fetch_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] start_ptr = '0;
    logic        abort = 1'b0;
    logic [11:0] m_address;
    logic        m_read;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;
    logic        m_readdatavalid = 1'b0;
    logic [31:0] desc_src, desc_dst, desc_next;
    logic [15:0] desc_ctrl, desc_len;
    logic        desc_valid;
    logic        desc_ready = 1'b0;
    logic        busy, chain_done, error;

    descriptor_fetch_master #(.ADDR_WIDTH(12), .DESC_WORDS(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_ptr(start_ptr), .abort(abort),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_next(desc_next),
        .desc_ctrl(desc_ctrl), .desc_len(desc_len), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .busy(busy), .chain_done(chain_done), .error(error)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    int n_assert = 0;
    int n_fail = 0;

    logic [11:0] rd_log[$];
    logic [31:0] hs_src[$], hs_dst[$];
    logic [15:0] hs_ctrl[$], hs_len[$];
    int          hs_rdcnt[$];
    int done_cnt, err_cnt, busy_cnt, valid_cycles, stall_seen, stall_viol, unstable;
    int ready_delay = 0;
    int age = 0;
    int stall_left = 0;
    logic [11:0] stall_addr = '0;
    bit          stall_prev = 0;
    bit          pend = 0;
    logic [11:0] pend_addr = '0;
    bit          hold = 0;
    logic [31:0] h_src, h_dst, h_next;
    logic [15:0] h_ctrl, h_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); hs_src.delete(); hs_dst.delete(); hs_ctrl.delete(); hs_len.delete();
        hs_rdcnt.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; valid_cycles = 0;
        stall_seen = 0; stall_viol = 0; unstable = 0;
    endtask

    task automatic load_desc(input int byte_addr, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        mem[byte_addr/4]     = w0;
        mem[byte_addr/4 + 1] = w1;
        mem[byte_addr/4 + 2] = w2;
        mem[byte_addr/4 + 3] = w3;
    endtask

    task automatic start_pulse(input logic [11:0] p);
        @(negedge clk);
        start_ptr = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reads(input string tag, input int base, input int n);
        check({tag, "_nreads"}, rd_log.size(), n);
        for (int i = 0; i < n && i < rd_log.size(); i++)
            check({tag, "_raddr"}, {20'b0, rd_log[i]}, base + 4 * i);
    endtask

    // Avalon slave (latency 1, programmable waitrequest) and DMA-side monitor, all on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            m_readdatavalid = 1'b0;
            if (pend) begin
                m_readdatavalid = 1'b1;
                m_readdata = mem[pend_addr[11:2]];
                pend = 0;
            end
            if (stall_prev && !(m_read && m_address == stall_addr)) stall_viol++;
            stall_prev = 0;
            if (m_read) begin
                if (stall_left > 0 && m_address == stall_addr) begin
                    m_waitrequest = 1'b1;
                    stall_left--;
                    stall_seen++;
                    stall_prev = 1;
                end else begin
                    m_waitrequest = 1'b0;
                    pend = 1;
                    pend_addr = m_address;
                    rd_log.push_back(m_address);
                end
            end else begin
                m_waitrequest = 1'b0;
            end

            if (chain_done) done_cnt++;
            if (error) err_cnt++;
            if (busy) busy_cnt++;
            if (hold) begin
                if (!desc_valid || desc_src != h_src || desc_dst != h_dst || desc_next != h_next ||
                    desc_ctrl != h_ctrl || desc_len != h_len) unstable++;
                hold = 0;
            end
            if (desc_valid) begin
                valid_cycles++;
                if (age >= ready_delay) begin
                    desc_ready = 1'b1;
                    hs_src.push_back(desc_src);
                    hs_dst.push_back(desc_dst);
                    hs_ctrl.push_back(desc_ctrl);
                    hs_len.push_back(desc_len);
                    hs_rdcnt.push_back(rd_log.size());
                end else begin
                    desc_ready = 1'b0;
                    hold = 1;
                    h_src = desc_src; h_dst = desc_dst; h_next = desc_next;
                    h_ctrl = desc_ctrl; h_len = desc_len;
                end
                age++;
            end else begin
                desc_ready = 1'b0;
                age = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        clear_logs();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_read", {31'b0, m_read}, 32'h0);
        check("rst_m_address", {20'b0, m_address}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_desc_valid", {31'b0, desc_valid}, 32'h0);
        check("rst_desc_src", desc_src, 32'h0);
        check("rst_desc_ctrl_len", {desc_ctrl, desc_len}, 32'h0);
        check("rst_pulses", {30'b0, chain_done, error}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single descriptor, with an ignored start while busy
        load_desc(12'h040, 32'h1000, 32'h2000, 32'h0, 32'h8000_0100);
        clear_logs();
        start_pulse(12'h040);
        check("t1_busy_after_start", {31'b0, busy}, 32'h1);
        repeat (3) @(negedge clk);
        start_ptr = 12'h300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t1_timeout", 100);
        check_reads("t1", 12'h040, 4);
        check("t1_nhs", hs_src.size(), 1);
        if (hs_src.size() == 1) begin
            check("t1_src", hs_src[0], 32'h1000);
            check("t1_dst", hs_dst[0], 32'h2000);
            check("t1_ctrl", {16'b0, hs_ctrl[0]}, 32'h8000);
            check("t1_len", {16'b0, hs_len[0]}, 32'h0100);
        end
        check("t1_done", done_cnt, 1);
        check("t1_err", err_cnt, 0);

        // two-descriptor chain 0x000 -> 0x010
        load_desc(12'h000, 32'hA000, 32'hB000, 32'h10, 32'h8000_0020);
        load_desc(12'h010, 32'hC000, 32'hD000, 32'h0, 32'h8000_0040);
        clear_logs();
        start_pulse(12'h000);
        wait_idle("t2_timeout", 200);
        check_reads("t2", 12'h000, 8);
        check("t2_nhs", hs_src.size(), 2);
        if (hs_src.size() == 2) begin
            check("t2_src0", hs_src[0], 32'hA000);
            check("t2_reads_at_hs0", hs_rdcnt[0], 4);
            check("t2_src1", hs_src[1], 32'hC000);
            check("t2_dst1", hs_dst[1], 32'hD000);
            check("t2_len1", {16'b0, hs_len[1]}, 32'h0040);
        end
        check("t2_done", done_cnt, 1);

        // second descriptor not owned by hardware
        mem[7] = 32'h0000_0040;
        clear_logs();
        start_pulse(12'h000);
        wait_idle("t3_timeout", 200);
        check_reads("t3", 12'h000, 8);
        check("t3_nhs", hs_src.size(), 1);
        check("t3_done", done_cnt, 1);
        check("t3_hold_ctrl_len", {desc_ctrl, desc_len}, 32'h0000_0040);
        check("t3_hold_src", desc_src, 32'hC000);

        // waitrequest on word1 and DMA backpressure
        load_desc(12'h080, 32'h1111_2222, 32'h3333_4444, 32'h0, 32'h8001_0008);
        clear_logs();
        stall_addr = 12'h084;
        stall_left = 3;
        ready_delay = 5;
        start_pulse(12'h080);
        wait_idle("t4_timeout", 200);
        ready_delay = 0;
        check_reads("t4", 12'h080, 4);
        check("t4_stall_cycles", stall_seen, 3);
        check("t4_addr_stable", stall_viol, 0);
        check("t4_desc_stable", unstable, 0);
        check("t4_valid_cycles", valid_cycles, 6);
        check("t4_nhs", hs_src.size(), 1);
        if (hs_src.size() == 1) begin
            check("t4_src", hs_src[0], 32'h1111_2222);
            check("t4_dst", hs_dst[0], 32'h3333_4444);
            check("t4_ctrl_len", {hs_ctrl[0], hs_len[0]}, 32'h8001_0008);
        end

        // misaligned start pointer
        clear_logs();
        start_pulse(12'h044);
        repeat (3) @(negedge clk);
        check("t5a_err", err_cnt, 1);
        check("t5a_nreads", rd_log.size(), 0);
        check("t5a_busy_cycles", busy_cnt, 0);

        // misaligned next pointer
        load_desc(12'h0C0, 32'h1, 32'h2, 32'h18, 32'h8000_0004);
        clear_logs();
        start_pulse(12'h0C0);
        wait_idle("t5b_timeout", 100);
        check("t5b_nhs", hs_src.size(), 1);
        check("t5b_err", err_cnt, 1);
        check("t5b_done", done_cnt, 0);
        check_reads("t5b", 12'h0C0, 4);

        // abort during the word2 WAIT
        load_desc(12'h0D0, 32'h5, 32'h6, 32'h0, 32'h8000_0001);
        clear_logs();
        start_pulse(12'h0D0);
        begin
            int k;
            k = 0;
            while (!(m_read && m_address == 12'h0D8) && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("t6_reach_word2", {31'b0, m_read}, 32'h1);
        end
        @(negedge clk);
        abort = 1'b1;
        wait_idle("t6_timeout", 100);
        abort = 1'b0;
        check_reads("t6", 12'h0D0, 4);
        check("t6_nhs", hs_src.size(), 0);
        check("t6_done", done_cnt, 1);
        check("t6_word3_fetched", {desc_ctrl, desc_len}, 32'h8000_0001);

        // asynchronous reset in the middle of REQ
        clear_logs();
        start_pulse(12'h040);
        check("t7_in_req", {31'b0, m_read}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("t7_rst_m_read", {31'b0, m_read}, 32'h0);
        check("t7_rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t7_after_busy", {31'b0, busy}, 32'h0);
        check("t7_after_nreads", rd_log.size(), 1);
        check("t7_after_desc_src", desc_src, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
